pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory wait states and
// taken-redirect flushes for a classic 5-stage pipeline, with event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IfId_Rs1,
  input  logic [4:0]  IfId_Rs2,
  input  logic        IfId_UsesRs2,
  input  logic        IdEx_MemRead,
  input  logic [4:0]  IdEx_Rd,
  input  logic        Ex_BranchTaken,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  output logic        PcWrite,
  output logic        IfIdWrite,
  output logic        IfIdFlush,
  output logic        IdExWrite,
  output logic        IdExFlush,
  output logic        ExMemWrite,
  output logic        MemWbBubble,
  output logic [1:0]  State,
  output logic [31:0] Stall_Count,
  output logic [31:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);

  state_e      state_q, state_d;
  logic [1:0]  redir_cnt_q, redir_cnt_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  logic mem_stall;
  logic load_use;
  logic redirect_taken;

  assign mem_stall = Mem_Req & ~Mem_Ready;
  assign load_use  = IdEx_MemRead & (IdEx_Rd != 5'd0) &
                     ((IdEx_Rd == IfId_Rs1) | (IfId_UsesRs2 & (IdEx_Rd == IfId_Rs2)));

  always_comb begin
    state_d        = state_q;
    redir_cnt_d    = redir_cnt_q;
    redirect_taken = 1'b0;
    PcWrite        = 1'b1;
    IfIdWrite      = 1'b1;
    IdExWrite      = 1'b1;
    ExMemWrite     = 1'b1;
    IfIdFlush      = 1'b0;
    IdExFlush      = 1'b0;
    MemWbBubble    = 1'b0;

    if (mem_stall) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemWrite  = 1'b0;
      MemWbBubble = 1'b1;
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
      end
    end else begin
      unique case (state_q)
        // A completed memory wait resolves exactly like a RUN cycle.
        ST_RUN, ST_MEM_WAIT: begin
          if (Ex_BranchTaken) begin
            IfIdFlush      = 1'b1;
            IdExFlush      = 1'b1;
            redirect_taken = 1'b1;
            redir_cnt_d    = BUBBLES;
            state_d        = (BUBBLES == 2'd0) ? ST_RUN : ST_REDIRECT;
          end else if (load_use) begin
            PcWrite   = 1'b0;
            IfIdWrite = 1'b0;
            IdExFlush = 1'b1;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_REDIRECT: begin
          IfIdFlush   = 1'b1;
          redir_cnt_d = redir_cnt_q - 2'd1;
          state_d     = (redir_cnt_q <= 2'd1) ? ST_RUN : ST_REDIRECT;
        end
        default: begin
          state_d     = ST_RUN;
          redir_cnt_d = 2'd0;
        end
      endcase
    end

    // Reset forces every pipeline register into its safe bubble/hold mode.
    if (!rst_n) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemWrite  = 1'b0;
      IfIdFlush   = 1'b1;
      IdExFlush   = 1'b1;
      MemWbBubble = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!PcWrite && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
    flush_count_d = flush_count_q;
    if (redirect_taken && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      redir_cnt_q   <= 2'd0;
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      redir_cnt_q   <= redir_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign State       = state_q;
  assign Stall_Count = stall_count_q;
  assign Flush_Count = flush_count_q;

endmodule
